lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 Port clk SHALL be an input, 1 bit wide; it is the system clock, and all state changes on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide; it is an asynchronous, active-high reset.
REQ-004 Port req_valid SHALL be an input, 1 bit wide; it signals a memory-operation request from the execute stage.
REQ-005 Port req_ready SHALL be an output, 1 bit wide; it signals that the LSU accepts a request.
REQ-006 Port req_wen SHALL be an input, 1 bit wide; 1 means store, 0 means load.
REQ-007 Port req_addr SHALL be an input, 32 bits wide; it is the byte address.
REQ-008 Port req_wdata SHALL be an input, 32 bits wide; it is the store data, right-aligned.
REQ-009 Port req_funct3 SHALL be an input, 3 bits wide; it carries the RISC-V load/store funct3 code.
REQ-010 Port mem_ren SHALL be an output, 1 bit wide; it is the read enable to the memory responder.
REQ-011 Port mem_wen SHALL be an output, 1 bit wide; it is the write enable to the memory responder.
REQ-012 Port mem_addr SHALL be an output, 32 bits wide; it is the shared read/write byte address.
REQ-013 Port mem_wdata SHALL be an output, 32 bits wide; it is the write data, right-aligned.
REQ-014 Port mem_bits SHALL be an output, 3 bits wide; it is the access size in bytes (1, 2 or 4).
REQ-015 Port mem_rdata SHALL be an input, 32 bits wide; it is the read data, right-aligned, valid the cycle after the edge that sampled mem_ren.
REQ-016 Port resp_valid SHALL be an output, 1 bit wide; it signals that a response is available.
REQ-017 Port resp_ready SHALL be an input, 1 bit wide; it signals that the consumer accepts the response.
REQ-018 Port resp_rdata SHALL be an output, 32 bits wide; it carries the extended load result (0 for stores and errors).
REQ-019 Port resp_err SHALL be an output, 1 bit wide; it flags a misaligned access or an illegal funct3.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, ISSUE, CAPTURE, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid && req_ready.
REQ-022 On acceptance, the LSU SHALL register req_wen, req_addr, req_wdata and req_funct3; later changes on the req_* inputs have no effect.
REQ-023 Loads SHALL decode as: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores SHALL decode as: 000 SB, 001 SH, 010 SW; every other code is illegal.
REQ-024 A request SHALL be misaligned if it is a half access with addr[0]=1, or a word access with addr[1:0]≠0.
REQ-025 A request that is illegal or misaligned SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, and mem_ren and mem_wen never assert for it.
REQ-026 A legal request SHALL go IDLE->ISSUE.
REQ-027 In ISSUE the LSU SHALL assert exactly one of mem_ren or mem_wen for exactly one cycle, and drive mem_addr, mem_bits, and mem_wdata (stores only) from the registered request.
REQ-028 mem_wdata SHALL carry the registered store data masked to the access size: SB is wdata[7:0] zero-extended, SH is wdata[15:0] zero-extended.
REQ-029 A store SHALL go ISSUE->RESP; a load SHALL go ISSUE->CAPTURE.
REQ-030 In CAPTURE the LSU SHALL register mem_rdata extended per funct3: LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW passes through; it then goes to RESP.
REQ-031 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_err SHALL be held stable until resp_ready=1.
REQ-032 The RESP->IDLE transition SHALL occur on the edge where resp_ready=1.
REQ-033 The LSU SHALL NOT accept a new request in the same cycle the response handshakes (req_ready=0 in RESP).
REQ-034 A load accepted at edge N SHALL present resp_valid from edge N+3; a store SHALL present it from edge N+2; an error request SHALL present it from edge N+1.
REQ-035 Outside ISSUE, mem_ren, mem_wen, mem_wdata and mem_bits SHALL be 0, and mem_addr SHALL hold the last registered address.
REQ-036 mem_ren and mem_wen SHALL be decoded from the state register only, so they deassert as soon as rst asserts.

Reset
REQ-037 While rst=1, the state SHALL be IDLE and the outputs SHALL be: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_bits=0.
REQ-038 If rst asserts in ISSUE, CAPTURE or RESP, the LSU SHALL abandon the in-flight operation with no response; any write already sampled by memory is not undone.
REQ-039 The first request after rst deasserts SHALL be accepted on the first rising edge with req_valid=1.

Verification
REQ-040 LB at addr 0x80000003, with mem_rdata=0x000000F0 in CAPTURE -> mem_ren=1 and mem_bits=1 for one cycle, then resp_rdata=0xFFFFFFF0, resp_err=0, resp_valid at N+3.
REQ-041 LHU at 0x80000002 returning 0x00008001 -> resp_rdata=0x00008001; LH returning the same data -> resp_rdata=0xFFFF8001.
REQ-042 SW at 0x80000010 with data 0xDEADBEEF -> one cycle with mem_wen=1, mem_addr=0x80000010, mem_wdata=0xDEADBEEF, mem_bits=4; resp_valid at N+2 with resp_rdata=0.
REQ-043 LW at 0x80000002, then funct3=011 -> each gives resp_err=1 at N+1, and mem_ren/mem_wen stay 0 throughout.
REQ-044 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable and req_ready=0; on resp_ready=1 -> IDLE the next cycle.
REQ-045 Assert rst asynchronously during ISSUE of SB -> mem_wen drops before the next edge, no response is produced, and outputs match REQ-037.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: accepts one RISC-V load/store request, drives a single-cycle
// memory strobe, extends load data and holds the response until it is consumed.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_bits,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t      r_state;
    logic        r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_issue;
    logic [2:0]  w_size;
    logic [31:0] w_wdata_masked;
    logic [31:0] w_rdata_ext;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_issue  = (r_state == ISSUE);

    // Decode legality straight from the request inputs so errors skip ISSUE.
    always_comb begin
        w_illegal = 1'b1;
        if (req_wen) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
                default:                w_illegal = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
                default:                                w_illegal = 1'b1;
            endcase
        end
    end

    assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_size = 3'd1;
            2'b01:   w_size = 3'd2;
            default: w_size = 3'd4;
        endcase
    end

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_wdata_masked = {24'h0, r_wdata[7:0]};
            2'b01:   w_wdata_masked = {16'h0, r_wdata[15:0]};
            default: w_wdata_masked = r_wdata;
        endcase
    end

    always_comb begin
        case (r_funct3)
            3'b000:  w_rdata_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  w_rdata_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b100:  w_rdata_ext = {24'h0, mem_rdata[7:0]};
            3'b101:  w_rdata_ext = {16'h0, mem_rdata[15:0]};
            default: w_rdata_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_wen    <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_funct3 <= 3'b000;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_wen    <= req_wen;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        r_rdata  <= 32'h0;
                        r_err    <= w_illegal || w_misaligned;
                        r_state  <= (w_illegal || w_misaligned) ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= r_wen ? RESP : CAPTURE;
                end
                CAPTURE: begin
                    r_rdata <= w_rdata_ext;
                    r_state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobes depend only on the state register so an async reset kills them at once.
    assign req_ready  = (r_state == IDLE);
    assign mem_ren    = w_issue && !r_wen;
    assign mem_wen    = w_issue && r_wen;
    assign mem_addr   = r_addr;
    assign mem_bits   = w_issue ? w_size : 3'd0;
    assign mem_wdata  = (w_issue && r_wen) ? w_wdata_masked : 32'h0;
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
